// File: rtl/pattern_generator.sv
// Host-programmed serial waveform generator: parses divider/load/start/stop
// commands, buffers sample bytes in a FIFO and plays them out LSB first.
module pattern_generator #(
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    rx_data,
  input  logic                          new_rx_data,
  output logic [7:0]                    tx_data,
  output logic                          new_tx_data,
  input  logic                          tx_busy,
  output logic                          output_pin,
  output logic                          running,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  localparam logic [7:0] ACK    = 8'h06;
  localparam logic [7:0] NAK    = 8'h15;
  localparam logic [7:0] C_DIV  = 8'h44;
  localparam logic [7:0] C_LEN  = 8'h4C;
  localparam logic [7:0] C_GO   = 8'h53;
  localparam logic [7:0] C_STOP = 8'h58;

  typedef enum logic [2:0] {IDLE, DIV_HI, DIV_LO, LEN, DATA} state_t;

  state_t               state_q, state_d;
  logic [7:0]           mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wptr_q, rptr_q;
  logic [LW-1:0]        count_q, count_d;
  logic [7:0]           div_hi_q, left_q;
  logic [DIV_WIDTH-1:0] div_q, cur_div_q, cnt_q;
  logic [7:0]           sh_q;
  logic [2:0]           bit_q;
  logic                 running_q, pin_q, ovf_q, pend_q, new_tx_q;
  logic [7:0]           reply_q, tx_q;

  logic       empty, full, is_go, is_stop, bnd;
  logic       push_req, push, drop, pop_go, pop_nxt, pop;
  logic       rep_v;
  logic [7:0] rep_c, head;

  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == LW'(FIFO_DEPTH));
    head     = mem_q[rptr_q];
    is_go    = new_rx_data && state_q == IDLE && rx_data == C_GO;
    is_stop  = new_rx_data && state_q == IDLE && rx_data == C_STOP;
    bnd      = running_q && (cnt_q == cur_div_q);
    pop_go   = is_go && !running_q && !empty;
    pop_nxt  = bnd && bit_q == 3'd7 && !empty;
    pop      = pop_go || pop_nxt;
    push_req = new_rx_data && state_q == DATA;
    // a same-cycle pop frees the slot a full FIFO needs
    push     = push_req && (!full || pop);
    drop     = push_req && !push;

    count_d = count_q;
    if (push && !pop)
      count_d = count_q + LW'(1);
    else if (pop && !push)
      count_d = count_q - LW'(1);

    state_d = state_q;
    rep_v   = 1'b0;
    rep_c   = ACK;
    if (new_rx_data) begin
      case (state_q)
        IDLE: begin
          unique case (1'b1)
            rx_data == C_DIV: state_d = DIV_HI;
            rx_data == C_LEN: state_d = LEN;
            rx_data == C_GO: begin
              rep_v = 1'b1;
              rep_c = (running_q || !empty) ? ACK : NAK;
            end
            rx_data == C_STOP: rep_v = 1'b1;
            default: begin
              rep_v = 1'b1;
              rep_c = NAK;
            end
          endcase
        end
        DIV_HI: state_d = DIV_LO;
        DIV_LO: begin
          state_d = IDLE;
          rep_v   = 1'b1;
        end
        LEN: begin
          if (rx_data == 8'd0) begin
            state_d = IDLE;
            rep_v   = 1'b1;
          end else begin
            state_d = DATA;
          end
        end
        DATA: begin
          if (left_q == 8'd1) begin
            state_d = IDLE;
            rep_v   = 1'b1;
            rep_c   = (ovf_q || drop) ? NAK : ACK;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem_q[wptr_q] <= rx_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      div_hi_q  <= '0;
      left_q    <= '0;
      div_q     <= '0;
      cur_div_q <= '0;
      cnt_q     <= '0;
      sh_q      <= '0;
      bit_q     <= '0;
      running_q <= 1'b0;
      pin_q     <= 1'b0;
      ovf_q     <= 1'b0;
      pend_q    <= 1'b0;
      reply_q   <= '0;
      tx_q      <= '0;
      new_tx_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (push)
        wptr_q <= wptr_q + AW'(1);
      if (pop)
        rptr_q <= rptr_q + AW'(1);

      if (new_rx_data) begin
        case (state_q)
          DIV_HI: div_hi_q <= rx_data;
          DIV_LO: div_q <= DIV_WIDTH'({div_hi_q, rx_data});
          LEN: begin
            left_q <= rx_data;
            ovf_q  <= 1'b0;
          end
          DATA: begin
            left_q <= left_q - 8'd1;
            if (left_q == 8'd1)
              ovf_q <= 1'b0;
            else if (drop)
              ovf_q <= 1'b1;
          end
          default: ;
        endcase
      end

      // bit period is latched per bit so divider loads apply at a boundary
      if (pop_go) begin
        running_q <= 1'b1;
        sh_q      <= head;
        pin_q     <= head[0];
        bit_q     <= '0;
        cnt_q     <= '0;
        cur_div_q <= div_q;
      end else if (bnd) begin
        cnt_q     <= '0;
        cur_div_q <= div_q;
        if (bit_q == 3'd7) begin
          if (!empty) begin
            sh_q  <= head;
            pin_q <= head[0];
            bit_q <= '0;
          end else begin
            running_q <= 1'b0;
            pin_q     <= 1'b0;
          end
        end else begin
          bit_q <= bit_q + 3'd1;
          sh_q  <= {1'b0, sh_q[7:1]};
          pin_q <= sh_q[1];
        end
      end else if (running_q) begin
        cnt_q <= cnt_q + DIV_WIDTH'(1);
      end

      if (is_stop) begin
        running_q <= 1'b0;
        pin_q     <= 1'b0;
        wptr_q    <= '0;
        rptr_q    <= '0;
        count_q   <= '0;
      end

      new_tx_q <= 1'b0;
      if (rep_v || pend_q) begin
        if (!tx_busy) begin
          new_tx_q <= 1'b1;
          tx_q     <= rep_v ? rep_c : reply_q;
          pend_q   <= 1'b0;
        end else begin
          pend_q <= 1'b1;
          if (rep_v)
            reply_q <= rep_c;
        end
      end
    end
  end

  assign tx_data     = tx_q;
  assign new_tx_data = new_tx_q;
  assign output_pin  = pin_q;
  assign running     = running_q;
  assign fifo_level  = count_q;

endmodule

// File: tb/tb_pattern_generator.sv
// Directed bench for pattern_generator: command vector table plus
// playback, busy-hold, overflow, streaming and reset sequences.
module tb_pattern_generator;

  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = '0;
  logic       new_rx_data = 1'b0;
  logic [7:0] tx_data;
  logic       new_tx_data;
  logic       tx_busy = 1'b0;
  logic       output_pin;
  logic       running;
  logic [4:0] fifo_level;

  int nvec = 0;
  int nmis = 0;

  pattern_generator #(.FIFO_DEPTH(16), .DIV_WIDTH(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_data     (rx_data),
    .new_rx_data (new_rx_data),
    .tx_data     (tx_data),
    .new_tx_data (new_tx_data),
    .tx_busy     (tx_busy),
    .output_pin  (output_pin),
    .running     (running),
    .fifo_level  (fifo_level)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] b;
    logic       rep;
    logic [7:0] code;
    int         lvl;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    new_rx_data = 1'b0;
    tx_busy = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // returns 1 time unit after the edge that sampled the strobe
  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1;
    rx_data = b;
    new_rx_data = 1'b1;
    @(posedge clk);
    #1 new_rx_data = 1'b0;
  endtask

  task automatic send_chk(input logic [7:0] b, input logic rep,
                          input logic [7:0] code, input int lvl);
    send_byte(b);
    chk($sformatf("strobe_%02h", b), {31'd0, new_tx_data}, {31'd0, rep});
    if (rep)
      chk($sformatf("reply_%02h", b), {24'd0, tx_data}, {24'd0, code});
    chk($sformatf("level_%02h", b), {27'd0, fifo_level}, lvl);
  endtask

  vec_t tbl[12];
  logic [7:0] stream[8];

  initial begin
    tbl[0]  = '{8'h41, 1'b1, NAK, 0};
    tbl[1]  = '{8'h53, 1'b1, NAK, 0};
    tbl[2]  = '{8'h44, 1'b0, ACK, 0};
    tbl[3]  = '{8'h00, 1'b0, ACK, 0};
    tbl[4]  = '{8'h02, 1'b1, ACK, 0};
    tbl[5]  = '{8'h4C, 1'b0, ACK, 0};
    tbl[6]  = '{8'h02, 1'b0, ACK, 0};
    tbl[7]  = '{8'h53, 1'b0, ACK, 1};
    tbl[8]  = '{8'h58, 1'b1, ACK, 2};
    tbl[9]  = '{8'h4C, 1'b0, ACK, 2};
    tbl[10] = '{8'h00, 1'b1, ACK, 2};
    tbl[11] = '{8'h58, 1'b1, ACK, 0};
    stream = '{8'h3C, 8'h81, 8'hF0, 8'h5A, 8'h0F, 8'hC3, 8'h96, 8'h01};

    // reset values
    #2;
    chk("rst_running", {31'd0, running}, 0);
    chk("rst_pin", {31'd0, output_pin}, 0);
    chk("rst_level", {27'd0, fifo_level}, 0);
    chk("rst_txd", {24'd0, tx_data}, 0);
    chk("rst_ntx", {31'd0, new_tx_data}, 0);
    do_reset();

    for (int i = 0; i < 12; i++) begin
      send_chk(tbl[i].b, tbl[i].rep, tbl[i].code, tbl[i].lvl);
      chk("tbl_running", {31'd0, running}, 0);
    end

    // divider 2, one byte A5, start
    do_reset();
    send_chk(8'h44, 0, ACK, 0);
    send_chk(8'h00, 0, ACK, 0);
    send_chk(8'h02, 1, ACK, 0);
    send_chk(8'h4C, 0, ACK, 0);
    send_chk(8'h01, 0, ACK, 0);
    send_chk(8'hA5, 1, ACK, 1);
    send_chk(8'h53, 1, ACK, 0);
    begin
      logic [7:0] pat;
      pat = 8'hA5;
      for (int i = 0; i < 24; i++) begin
        chk($sformatf("a5_pin%0d", i), {31'd0, output_pin},
            {31'd0, pat[i/3]});
        chk($sformatf("a5_run%0d", i), {31'd0, running}, 1);
        @(posedge clk);
        #1;
      end
    end
    chk("a5_run_end", {31'd0, running}, 0);
    chk("a5_pin_end", {31'd0, output_pin}, 0);
    chk("a5_noreply", {31'd0, new_tx_data}, 0);

    // reply held while busy
    do_reset();
    tx_busy = 1'b1;
    send_byte(8'h99);
    begin
      int seen;
      seen = new_tx_data ? 1 : 0;
      repeat (48) begin
        @(posedge clk);
        #1 if (new_tx_data) seen++;
      end
      chk("busy_strobes", seen, 0);
    end
    tx_busy = 1'b0;
    @(posedge clk);
    #1;
    chk("busy_rel_ntx", {31'd0, new_tx_data}, 1);
    chk("busy_rel_txd", {24'd0, tx_data}, {24'd0, NAK});
    @(posedge clk);
    #1;
    chk("busy_single", {31'd0, new_tx_data}, 0);

    // overflow
    do_reset();
    send_chk(8'h4C, 0, ACK, 0);
    send_chk(8'h14, 0, ACK, 0);
    for (int i = 0; i < 20; i++)
      send_chk(8'(i + 8'h40), (i == 19), NAK, (i < 16) ? i + 1 : 16);
    send_chk(8'h58, 1, ACK, 0);
    chk("ovf_cmd_after", {31'd0, running}, 0);

    // divider 0, streaming while playing
    do_reset();
    send_chk(8'h4C, 0, ACK, 0);
    send_chk(8'h04, 0, ACK, 0);
    for (int i = 0; i < 4; i++)
      send_chk(stream[i], (i == 3), ACK, i + 1);
    send_chk(8'h53, 1, ACK, 3);
    fork
      begin
        send_byte(8'h4C);
        send_byte(8'h04);
        for (int i = 4; i < 8; i++) send_byte(stream[i]);
      end
      begin
        int bad;
        bad = 0;
        for (int i = 0; i < 64; i++) begin
          logic [7:0] cur;
          cur = stream[i/8];
          if (output_pin !== cur[i%8] || running !== 1'b1) bad++;
          @(posedge clk);
          #1;
        end
        chk("stream_bit_errors", bad, 0);
        chk("stream_run_end", {31'd0, running}, 0);
        chk("stream_level_end", {27'd0, fifo_level}, 0);
      end
    join

    // reset mid-playback and mid-load
    do_reset();
    send_chk(8'h44, 0, ACK, 0);
    send_chk(8'h00, 0, ACK, 0);
    send_chk(8'h05, 1, ACK, 0);
    send_chk(8'h4C, 0, ACK, 0);
    send_chk(8'h01, 0, ACK, 0);
    send_chk(8'hFF, 1, ACK, 1);
    send_chk(8'h53, 1, ACK, 0);
    send_chk(8'h4C, 0, ACK, 0);
    send_chk(8'h03, 0, ACK, 0);
    send_chk(8'hAA, 0, ACK, 1);
    chk("mid_running", {31'd0, running}, 1);
    chk("mid_pin", {31'd0, output_pin}, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_running", {31'd0, running}, 0);
    chk("arst_pin", {31'd0, output_pin}, 0);
    chk("arst_level", {27'd0, fifo_level}, 0);
    chk("arst_txd", {24'd0, tx_data}, 0);
    chk("arst_ntx", {31'd0, new_tx_data}, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    send_chk(8'h41, 1, NAK, 0);
    send_chk(8'h53, 1, NAK, 0);
    chk("post_rst_running", {31'd0, running}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
